bus_router: RTL and testbench
=============================

# bus_router

Parametrised, registered successor to the three-slave combinational decoder: one master port, `NUM_SLAVES` slave ports with per-slave base/mask address windows. Each transfer runs through a small FSM that latches the request, drives exactly one slave, and returns one registered response. Unmapped addresses and stalled slaves complete with an error flag instead of hanging the LSU. Sits between the LSU and the RAM/UART/Timer/other peripherals.

## Interface
- `NUM_SLAVES`, 4: number of slave ports, 1..8.
- `SLV_BASE`, {32'h4000_8000, 32'h4000_4000, 32'h4000_0000, 32'h0000_0000}: flattened 32-bit base per slave; slave i is bits [32i+31:32i].
- `SLV_MASK`, {32'hFFFF_C000, 32'hFFFF_C000, 32'hFFFF_C000, 32'hC000_0000}: flattened 32-bit compare mask per slave.
- `TIMEOUT_CYC`, 255: slave-wait limit in cycles, 1..65535.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `m_addr`  in  32  master address.
- `m_wdata`  in  32  write data.
- `m_wstrb`  in  4  byte strobes.
- `m_write`  in  1  1 = write.
- `m_enable`  in  1  request; held until `m_ready`.
- `m_rdata`  out  32  read data, valid with `m_ready`.
- `m_ready`  out  1  one-cycle completion pulse.
- `m_err`  out  1  error flag, valid with `m_ready`.
- `s_addr` / `s_wdata`  out  32*NUM_SLAVES each  latched address/data, replicated to all slaves.
- `s_wstrb`  out  4*NUM_SLAVES  latched strobes.
- `s_write`, `s_enable`  out  NUM_SLAVES each  per-slave write and enable.
- `s_rdata`  in  32*NUM_SLAVES  per-slave read data.
- `s_ready`  in  NUM_SLAVES  per-slave ready.

## Operation
- Decode: slave i hits when `(m_addr & SLV_MASK[i]) == SLV_BASE[i]`. If several slaves hit, the lowest index wins.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, `m_enable`=1 with a hit: latch addr/wdata/wstrb/write and the one-hot select, clear the timer, go to ACCESS.
- IDLE, `m_enable`=1 with no hit: set `m_err`=1, `m_rdata`=32'h0, go to RESP. No slave is enabled.
- ACCESS: drive `s_enable[sel]`=1 from a register and keep every other slave enable at 0.
  - `s_ready[sel]`=1: capture `s_rdata[sel]` into `m_rdata` (also captured on writes), set `m_err`=0, drop `s_enable`, go to RESP.
  - Timer reaches `TIMEOUT_CYC` (only with `BUS_ROUTER_TIMEOUT_EN`): set `m_err`=1, `m_rdata`=32'h0, drop `s_enable`, go to RESP. A ready in that same cycle wins over the timeout.
- RESP: `m_ready`=1 for exactly one cycle, then go to IDLE. `m_enable` is ignored while in RESP.
- The `s_ready` inputs of unselected slaves are ignored.
- Master changes to `m_addr` etc. during ACCESS or RESP have no effect, because the request is latched.
- Reset values: all outputs 0, FSM in IDLE, timer 0, select 0. Reset asserted mid-transfer aborts the transfer immediately with no `m_ready` pulse.

## Timing
- Cycle 0: `m_enable` sampled in IDLE.
- Cycle 1: `s_enable`=1.
- Slave ready sampled in cycle k ≥ 1; `m_ready` is high in cycle k+1.
- Zero-wait slave (ready in cycle 1): `m_ready` in cycle 2, so 2-cycle latency.
- Decode error: `m_ready` in cycle 1.
- Back-to-back: the master drops or re-presents `m_enable` after seeing `m_ready`. The next request is accepted at the earliest the cycle after RESP, giving one transfer per 3 cycles minimum.
- Timeout: the timer increments in every ACCESS cycle without ready. The error `m_ready` appears `TIMEOUT_CYC`+1 cycles after `s_enable` first rises.

## Configuration
- `BUS_ROUTER_TIMEOUT_EN` defined: the timeout counter is built (width `$clog2(TIMEOUT_CYC+1)`) and the ACCESS timeout exit is active.
- Undefined: no counter is built and ACCESS waits indefinitely for `s_ready`. Decode errors still report `m_err`.

## Structure
- Shared package `bus_pkg`: FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2) and the default memory-map constants (RAM, UART, TIMER bases and masks).
- One sub-module `bus_addr_decode`: purely combinational. Takes the address plus the base/mask vectors and produces a one-hot hit vector and a `miss` signal. Lowest-index priority is applied inside it.

## Test plan
- Read 0x0000_0100, slave 0 ready in cycle 1 with rdata 0x1234_5678 -> `m_ready` in cycle 2, `m_rdata`=0x1234_5678, `m_err`=0, only `s_enable[0]` ever high.
- Write 0x4000_4008 with wstrb 4'b0011 and data 0xAABB_CCDD, slave 2 ready after 3 wait cycles -> `s_wstrb[11:8]`=4'b0011 and `s_wdata[95:64]`=0xAABB_CCDD held stable throughout; `m_ready` comes once.
- Access 0x8000_0000 -> `m_ready`=1 and `m_err`=1 in cycle 1, `m_rdata`=0, no `s_enable` asserted.
- `TIMEOUT_CYC`=4 with the macro defined, slave 1 never ready -> `m_err`=1 with `m_ready` 5 cycles after `s_enable[1]` rises, then IDLE. With the macro undefined the bench sees no response for 100 cycles.
- Slave ready in the exact timeout cycle -> `m_err`=0 and slave data returned.
- `rst_n` pulsed low during ACCESS -> all outputs 0 asynchronously, no `m_ready`. A fresh read after release completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the bus router: FSM state encoding and the
// default memory map (RAM, UART, TIMER and an auxiliary peripheral window).
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [31:0] RAM_BASE   = 32'h0000_0000;
    localparam logic [31:0] RAM_MASK   = 32'hC000_0000;
    localparam logic [31:0] UART_BASE  = 32'h4000_0000;
    localparam logic [31:0] UART_MASK  = 32'hFFFF_C000;
    localparam logic [31:0] TIMER_BASE = 32'h4000_4000;
    localparam logic [31:0] TIMER_MASK = 32'hFFFF_C000;
    localparam logic [31:0] AUX_BASE   = 32'h4000_8000;
    localparam logic [31:0] AUX_MASK   = 32'hFFFF_C000;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decoder: compares the address against each
// base/mask window and returns a one-hot hit vector (lowest index wins
// when windows overlap) plus a miss flag when no window matches.
module bus_addr_decode #(
    parameter int NUM_SLAVES = 4
) (
    input  logic [31:0]              addr,
    input  logic [32*NUM_SLAVES-1:0] base,
    input  logic [32*NUM_SLAVES-1:0] mask,
    output logic [NUM_SLAVES-1:0]    hit,
    output logic                     miss
);

    logic found;

    // Scan windows from index 0 upward; the first match claims the access.
    always_comb begin
        hit   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!found && ((addr & mask[32*i +: 32]) == base[32*i +: 32])) begin
                hit[i] = 1'b1;
                found  = 1'b1;
            end
        end
        miss = ~found;
    end

endmodule

// File: rtl/bus_router.sv
// Registered single-master bus router. Each request is latched, routed to
// exactly one slave, and answered with a one-cycle m_ready pulse carrying
// read data and an error flag. Unmapped addresses answer with m_err.
// Optional feature macro: BUS_ROUTER_TIMEOUT_EN builds a slave-wait timer
// that ends a stalled access with m_err after TIMEOUT_CYC waiting cycles.
module bus_router
    import bus_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter logic [32*NUM_SLAVES-1:0] SLV_BASE = {AUX_BASE, TIMER_BASE, UART_BASE, RAM_BASE},
    parameter logic [32*NUM_SLAVES-1:0] SLV_MASK = {AUX_MASK, TIMER_MASK, UART_MASK, RAM_MASK},
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              m_addr,
    input  logic [31:0]              m_wdata,
    input  logic [3:0]               m_wstrb,
    input  logic                     m_write,
    input  logic                     m_enable,
    output logic [31:0]              m_rdata,
    output logic                     m_ready,
    output logic                     m_err,
    output logic [32*NUM_SLAVES-1:0] s_addr,
    output logic [32*NUM_SLAVES-1:0] s_wdata,
    output logic [4*NUM_SLAVES-1:0]  s_wstrb,
    output logic [NUM_SLAVES-1:0]    s_write,
    output logic [NUM_SLAVES-1:0]    s_enable,
    input  logic [32*NUM_SLAVES-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]    s_ready
);

    state_t                 state_q, state_d;
    logic [NUM_SLAVES-1:0]  sel_q, sel_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             wstrb_q, wstrb_d;
    logic [NUM_SLAVES-1:0]  s_enable_q, s_enable_d;
    logic [NUM_SLAVES-1:0]  s_write_q, s_write_d;
    logic [31:0]            m_rdata_q, m_rdata_d;
    logic                   m_ready_q, m_ready_d;
    logic                   m_err_q, m_err_d;

    logic [NUM_SLAVES-1:0]  hit;
    logic                   miss;
    logic [31:0]            sel_rdata;
    logic                   sel_ready;

`ifdef BUS_ROUTER_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYC + 1);
    logic [TIMER_W-1:0]     timer_q, timer_d;
`endif

    bus_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES)
    ) u_decode (
        .addr (m_addr),
        .base (SLV_BASE),
        .mask (SLV_MASK),
        .hit  (hit),
        .miss (miss)
    );

    // Latched request is broadcast to every slave; only enables are per-slave.
    assign s_addr   = {NUM_SLAVES{addr_q}};
    assign s_wdata  = {NUM_SLAVES{wdata_q}};
    assign s_wstrb  = {NUM_SLAVES{wstrb_q}};
    assign s_write  = s_write_q;
    assign s_enable = s_enable_q;
    assign m_rdata  = m_rdata_q;
    assign m_ready  = m_ready_q;
    assign m_err    = m_err_q;

    // One-hot select picks the active slave's data and ready; others are ignored.
    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                sel_rdata = sel_rdata | s_rdata[32*i +: 32];
                sel_ready = sel_ready | s_ready[i];
            end
        end
    end

    // Next-state logic for the IDLE -> ACCESS -> RESP transfer sequence.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        s_enable_d = s_enable_q;
        s_write_d  = s_write_q;
        m_rdata_d  = m_rdata_q;
        m_err_d    = m_err_q;
        m_ready_d  = 1'b0;
`ifdef BUS_ROUTER_TIMEOUT_EN
        timer_d    = timer_q;
`endif
        case (state_q)
            IDLE: begin
                if (m_enable) begin
                    if (!miss) begin
                        addr_d     = m_addr;
                        wdata_d    = m_wdata;
                        wstrb_d    = m_wstrb;
                        sel_d      = hit;
                        s_enable_d = hit;
                        s_write_d  = hit & {NUM_SLAVES{m_write}};
`ifdef BUS_ROUTER_TIMEOUT_EN
                        timer_d    = '0;
`endif
                        state_d    = ACCESS;
                    end else begin
                        m_err_d   = 1'b1;
                        m_rdata_d = '0;
                        m_ready_d = 1'b1;
                        state_d   = RESP;
                    end
                end
            end
            ACCESS: begin
                // Ready is checked first so it wins over a coincident timeout.
                if (sel_ready) begin
                    m_rdata_d  = sel_rdata;
                    m_err_d    = 1'b0;
                    m_ready_d  = 1'b1;
                    s_enable_d = '0;
                    s_write_d  = '0;
                    state_d    = RESP;
`ifdef BUS_ROUTER_TIMEOUT_EN
                end else if (timer_q == TIMER_W'(TIMEOUT_CYC)) begin
                    m_rdata_d  = '0;
                    m_err_d    = 1'b1;
                    m_ready_d  = 1'b1;
                    s_enable_d = '0;
                    s_write_d  = '0;
                    state_d    = RESP;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            s_enable_q <= '0;
            s_write_q  <= '0;
            m_rdata_q  <= '0;
            m_ready_q  <= 1'b0;
            m_err_q    <= 1'b0;
`ifdef BUS_ROUTER_TIMEOUT_EN
            timer_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            s_enable_q <= s_enable_d;
            s_write_q  <= s_write_d;
            m_rdata_q  <= m_rdata_d;
            m_ready_q  <= m_ready_d;
            m_err_q    <= m_err_d;
`ifdef BUS_ROUTER_TIMEOUT_EN
            timer_q    <= timer_d;
`endif
        end
    end

endmodule

// File: tb/tb_bus_router.sv
// Scoreboard bench for bus_router: a stimulus process issues transfers and
// queues the expected response from an address-map model; a monitor pops
// and compares on every m_ready. A responder process models the slaves.
module tb_bus_router;

    localparam int N = 4;
    localparam int T = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      m_addr, m_wdata;
    logic [3:0]       m_wstrb;
    logic             m_write, m_enable;
    logic [31:0]      m_rdata;
    logic             m_ready, m_err;
    logic [32*N-1:0]  s_addr, s_wdata, s_rdata;
    logic [4*N-1:0]   s_wstrb;
    logic [N-1:0]     s_write, s_enable, s_ready;

    always #5 clk = ~clk;

    bus_router #(.NUM_SLAVES(N), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_write(m_write), .m_enable(m_enable),
        .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_write(s_write), .s_enable(s_enable),
        .s_rdata(s_rdata), .s_ready(s_ready)
    );

    // Reference memory map (slave index order).
    logic [31:0] win_base [N] = '{32'h0000_0000, 32'h4000_0000, 32'h4000_4000, 32'h4000_8000};
    logic [31:0] win_mask [N] = '{32'hC000_0000, 32'hFFFF_C000, 32'hFFFF_C000, 32'hFFFF_C000};

    typedef struct { logic [31:0] rdata; logic err; } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // Current transaction as seen by the responder and monitor.
    int          act_idx = -1;
    int          cur_wait = 0;
    bit          cur_hang = 0;
    logic [31:0] cur_rdata, cur_addr, cur_wdata;
    logic [3:0]  cur_wstrb;
    logic        cur_write;
    int          wcnt = 0;
    logic [N-1:0]    rdy_v;
    logic [32*N-1:0] rd_v;

    function automatic int route(input logic [31:0] a);
        for (int i = 0; i < N; i++)
            if ((a & win_mask[i]) == win_base[i]) return i;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Slave models: noise on unselected slaves, scripted wait/data on the target.
    always @(negedge clk) begin
        rdy_v = N'($urandom);
        for (int i = 0; i < N; i++) rd_v[32*i +: 32] = $urandom;
        if (act_idx >= 0) begin
            rdy_v[act_idx] = 1'b0;
            rd_v[32*act_idx +: 32] = cur_rdata;
            if (s_enable[act_idx]) begin
                if (!cur_hang && wcnt >= cur_wait) rdy_v[act_idx] = 1'b1;
                wcnt++;
            end else begin
                wcnt = 0;
            end
        end
        s_ready = rdy_v;
        s_rdata = rd_v;
    end

    // Monitor: scoreboard pop on m_ready, and slave-side checks while enabled.
    always @(negedge clk) begin
        exp_t e;
        logic [N-1:0] exp_en;
        if (rst_n) begin
            if (m_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_m_ready actual=1 expected=0");
                end else begin
                    e = exp_q.pop_front();
                    check("m_rdata", m_rdata, e.rdata);
                    check("m_err", 32'(m_err), 32'(e.err));
                end
            end
            if (s_enable != '0) begin
                exp_en = (act_idx >= 0) ? N'(1 << act_idx) : '0;
                check("s_enable_onehot", 32'(s_enable), 32'(exp_en));
                check("s_write", 32'(s_write), cur_write ? 32'(exp_en) : 32'h0);
                for (int i = 0; i < N; i++) begin
                    check("s_addr", s_addr[32*i +: 32], cur_addr);
                    check("s_wdata", s_wdata[32*i +: 32], cur_wdata);
                    check("s_wstrb", 32'(s_wstrb[4*i +: 4]), 32'(cur_wstrb));
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_m_ready"}, 32'(m_ready), 32'h0);
        check({tag, "_m_err"}, 32'(m_err), 32'h0);
        check({tag, "_m_rdata"}, m_rdata, 32'h0);
        check({tag, "_s_enable"}, 32'(s_enable), 32'h0);
        check({tag, "_s_write"}, 32'(s_write), 32'h0);
        check({tag, "_s_addr"}, 32'(|s_addr), 32'h0);
        check({tag, "_s_wdata"}, 32'(|s_wdata), 32'h0);
        check({tag, "_s_wstrb"}, 32'(s_wstrb), 32'h0);
    endtask

    // Issue one transfer; expect_resp=0 means the bench expects silence for 100 cycles.
    task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic write,
                        input int wt, input bit hang, input logic [31:0] rdata,
                        input bit expect_resp);
        int idx, lat, n, limit;
        bit got;
        exp_t e;
        @(negedge clk);
        idx = route(addr);
        act_idx = idx; cur_wait = wt; cur_hang = hang; cur_rdata = rdata;
        cur_addr = addr; cur_wdata = wdata; cur_wstrb = wstrb; cur_write = write;
        if (idx < 0) begin
            e.rdata = 32'h0; e.err = 1'b1; lat = 1;
        end else if (hang) begin
            e.rdata = 32'h0; e.err = 1'b1; lat = T + 2;
        end else begin
            e.rdata = rdata; e.err = 1'b0; lat = 2 + wt;
        end
        if (expect_resp) exp_q.push_back(e);
        m_addr = addr; m_wdata = wdata; m_wstrb = wstrb; m_write = write; m_enable = 1'b1;
        limit = expect_resp ? 200 : 100;
        n = 0; got = 0;
        while (n < limit) begin
            @(negedge clk);
            n++;
            if (m_ready) begin got = 1; break; end
            m_addr = $urandom; m_wdata = $urandom; m_wstrb = 4'($urandom); m_write = 1'($urandom);
        end
        m_enable = 1'b0;
        if (expect_resp) begin
            check("got_response", 32'(got), 32'h1);
            check("latency", 32'(n), 32'(lat));
        end else begin
            check("no_response", 32'(got), 32'h0);
        end
    endtask

    initial begin
        rst_n = 1'b0; m_enable = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0; m_write = 1'b0;
        s_ready = '0; s_rdata = '0;
        cur_rdata = '0; cur_addr = '0; cur_wdata = '0; cur_wstrb = '0; cur_write = 1'b0;
        #12;
        check_outputs_zero("reset");
        @(negedge clk); rst_n = 1'b1;

        // Zero-wait read from RAM.
        xfer(32'h0000_0100, 32'h0, 4'h0, 1'b0, 0, 0, 32'h1234_5678, 1);
        // Write to TIMER window with three wait cycles.
        xfer(32'h4000_4008, 32'hAABB_CCDD, 4'b0011, 1'b1, 3, 0, 32'h0BAD_F00D, 1);
        // Unmapped address.
        xfer(32'h8000_0000, 32'h5555_5555, 4'hF, 1'b0, 0, 0, 32'h0, 1);

`ifdef BUS_ROUTER_TIMEOUT_EN
        // Stalled UART times out; then ready in the exact timeout cycle wins.
        xfer(32'h4000_0010, 32'h0, 4'h0, 1'b0, 0, 1, 32'hDEAD_BEEF, 1);
        xfer(32'h4000_0014, 32'h0, 4'h0, 1'b0, T, 0, 32'hCAFE_0001, 1);
`else
        // Without the timer a stalled slave never completes; recover with reset.
        xfer(32'h4000_0010, 32'h0, 4'h0, 1'b0, 0, 1, 32'hDEAD_BEEF, 0);
        @(negedge clk); rst_n = 1'b0; act_idx = -1;
        @(negedge clk); rst_n = 1'b1;
`endif

        // Reset in the middle of an access aborts with no response.
        @(negedge clk);
        act_idx = 0; cur_wait = 20; cur_hang = 0; cur_rdata = 32'h7777_0000;
        cur_addr = 32'h0000_0200; cur_wdata = 32'h1111_2222; cur_wstrb = 4'hF; cur_write = 1'b1;
        m_addr = cur_addr; m_wdata = cur_wdata; m_wstrb = cur_wstrb; m_write = 1'b1; m_enable = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_abort_s_enable", 32'(s_enable), 32'h1);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("abort");
        m_enable = 1'b0; act_idx = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        xfer(32'h0000_0300, 32'h0, 4'h0, 1'b0, 1, 0, 32'h0F0F_A5A5, 1);

        // Randomized traffic across the map, including misses and noise on idle slaves.
        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            case ($urandom_range(0, 3))
                0: a = $urandom;
                1: a = 32'h4000_0000 | 32'($urandom_range(0, 32'hFFFF));
                2: a = $urandom & 32'h3FFF_FFFF;
                default: a = 32'h4000_0000 | 32'($urandom_range(0, 32'h3_FFFF));
            endcase
            xfer(a, $urandom, 4'($urandom), 1'($urandom), $urandom_range(0, T - 1), 0, $urandom, 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
